multicycle_mcu: RTL and testbench
=================================

// Module: multicycle_mcu
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath (shared instr/data memory, IR, A/B, ALUOut regs).
//  Takes opcode from IR and a memory-ready handshake; drives every datapath strobe/mux select
//  per cycle. Supports R-type, lw, sw, beq, addi, j; unknown opcode halts. alu_cu decodes funct.
// PARAMETERS
//  none (state encoding and opcodes fixed below)
// PORTS
//  clk            in   1  clock, all state on rising edge
//  reset          in   1  asynchronous, active-low; 0 forces IDLE immediately
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  mem_ready      in   1  memory completes the current access at this clock edge
//  mem_req        out  1  memory access request (held until mem_ready)
//  mem_we         out  1  write qualifier for mem_req
//  iord           out  1  address sel: 0=PC, 1=ALUOut
//  ir_we          out  1  load IR from memory read data
//  pc_we          out  1  unconditional PC write
//  branch         out  1  PC write if ALU eq (ANDed outside)
//  pc_src         out  2  0=ALU result, 1=ALUOut, 2=jump target {pc[31:28],instr[25:0],2'b0}
//  alu_srca_sel   out  1  0=PC, 1=reg A
//  alu_srcb_sel   out  2  0=reg B, 1=32'd4, 2=sign_imm, 3=sign_imm<<2
//  aluop          out  4  0=ADD, 1=SUB, 2=FUNCT (alu_cu decodes funct)
//  reg_we         out  1  register file write
//  wreg_dst_sel   out  1  0=rt, 1=rd
//  wrbck_data_sel out  1  0=ALUOut, 1=memory data reg
//  instr_done     out  1  1-cycle pulse in final state of each instruction
//  halted         out  1  1 while in HALT
//  state_debug    out  4  current state encoding
// BEHAVIOUR
//  States (4b): IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 RTYPE_EX=7 RTYPE_WB=8
//   BEQ_EX=9 ADDI_EX=10 ADDI_WB=11 JMP_EX=12 HALT=15; others unreachable, decode to IDLE outputs, next=FETCH.
//  Reset low: state=IDLE asynchronously; in IDLE all outputs 0 (state_debug=0). IDLE->FETCH on first edge after release.
//  Outputs decode from state only, except FETCH ir_we/pc_we = mem_ready. Unlisted outputs 0.
//  FETCH: mem_req=1,iord=0,srca=0,srcb=1,ADD,pc_src=0; stay while !mem_ready; ->DECODE when mem_ready.
//  DECODE: srca=0,srcb=3,ADD (branch target->ALUOut). Next by opcode: 100011/101011->MEMADR,
//   000000->RTYPE_EX, 000100->BEQ_EX, 001000->ADDI_EX, 000010->JMP_EX, other->HALT.
//  MEMADR: srca=1,srcb=2,ADD; ->MEMRD if lw else MEMWR (opcode held stable by IR).
//  MEMRD: mem_req=1,iord=1; wait for mem_ready; ->MEMWB.
//  MEMWB: reg_we=1,wreg_dst_sel=0,wrbck=1,instr_done=1; ->FETCH.
//  MEMWR: mem_req=1,mem_we=1,iord=1; on mem_ready instr_done=1,->FETCH; else stay.
//  RTYPE_EX: srca=1,srcb=0,aluop=FUNCT; ->RTYPE_WB. RTYPE_WB: reg_we=1,dst=1,wrbck=0,done; ->FETCH.
//  BEQ_EX: srca=1,srcb=0,SUB,branch=1,pc_src=1,done; ->FETCH.
//  ADDI_EX: srca=1,srcb=2,ADD; ->ADDI_WB. ADDI_WB: reg_we=1,dst=0,wrbck=0,done; ->FETCH.
//  JMP_EX: pc_we=1,pc_src=2,done; ->FETCH.
//  HALT: halted=1, no strobes, stays until reset.
//  Min cycles: lw 5, sw/R/addi 4, beq/j 3; +1 per cycle mem_ready low in FETCH/MEMRD/MEMWR.
//  mem_req/mem_we/iord stable while waiting; mem_ready outside request states ignored.
//  Reset mid-instruction: abort at once, no further strobes, restart at FETCH; PC owned by datapath.
// TESTING
//  reset low 3 cyc, release, mem_ready=1 -> IDLE outputs 0, then state 1 with mem_req=1,ir_we=1,pc_we=1.
//  R-type opcode 000000, ready=1 -> states 1,2,7,8,1; reg_we=1,wreg_dst_sel=1 only in 8; done once.
//  lw 100011, mem_ready low 2 cyc in MEMRD -> 1,2,3,4,4,4,5; iord=1 held; reg_we+wrbck=1 in 5.
//  sw 101011 -> MEMWR mem_req=mem_we=iord=1 until ready; reg_we never 1; back to FETCH.
//  beq 000100 -> BEQ_EX branch=1,aluop=1,pc_src=1; j 000010 -> JMP_EX pc_we=1,pc_src=2.
//  opcode 111111 in DECODE -> HALT, halted=1 for 20 cyc; reset low in MEMRD -> IDLE, mem_req=0 same cycle.

Source files
------------

// File: rtl/multicycle_mcu_if.sv
// Bus between the multi-cycle MIPS controller and its datapath/memory.
// The controller (master) receives the IR opcode and the memory ready
// handshake, and drives every datapath strobe and mux select.
//   opcode         : IR[31:26], valid from DECODE onward
//   mem_ready      : memory completes the current access at this edge
//   mem_req/mem_we : memory request and its write qualifier
//   iord           : memory address select (0=PC, 1=ALUOut)
//   ir_we, pc_we   : IR load, unconditional PC write
//   branch         : PC write qualified by ALU zero (ANDed in datapath)
//   pc_src         : 0=ALU result, 1=ALUOut, 2=jump target
//   alu_srca_sel   : 0=PC, 1=reg A
//   alu_srcb_sel   : 0=reg B, 1=4, 2=sign_imm, 3=sign_imm<<2
//   aluop          : 0=ADD, 1=SUB, 2=FUNCT
//   reg_we, wreg_dst_sel, wrbck_data_sel : register file write controls
//   instr_done     : one-cycle pulse in the last state of an instruction
//   halted         : high while in HALT
//   state_debug    : current state encoding
interface multicycle_mcu_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic       branch;
  logic [1:0] pc_src;
  logic       alu_srca_sel;
  logic [1:0] alu_srcb_sel;
  logic [3:0] aluop;
  logic       reg_we;
  logic       wreg_dst_sel;
  logic       wrbck_data_sel;
  logic       instr_done;
  logic       halted;
  logic [3:0] state_debug;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src,
           alu_srca_sel, alu_srcb_sel, aluop, reg_we, wreg_dst_sel,
           wrbck_data_sel, instr_done, halted, state_debug
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src,
           alu_srca_sel, alu_srcb_sel, aluop, reg_we, wreg_dst_sel,
           wrbck_data_sel, instr_done, halted, state_debug
  );
endinterface

// File: rtl/multicycle_mcu.sv
// Moore FSM sequencing a multi-cycle MIPS datapath with a shared
// instruction/data memory. Supports R-type, lw, sw, beq, addi and j;
// an unknown opcode parks the controller in HALT until reset.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-low; forces IDLE immediately
//   bus   : multicycle_mcu_if.master (opcode/mem_ready in, strobes out)
module multicycle_mcu (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_mcu_if.master       bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,
    BEQ_EX   = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    JMP_EX   = 4'd12,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;

  state_t state, state_nxt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs; FETCH ir_we/pc_we are the only
  // outputs that also follow mem_ready.
  always_comb begin
    state_nxt          = state;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.iord           = 1'b0;
    bus.ir_we          = 1'b0;
    bus.pc_we          = 1'b0;
    bus.branch         = 1'b0;
    bus.pc_src         = 2'd0;
    bus.alu_srca_sel   = 1'b0;
    bus.alu_srcb_sel   = 2'd0;
    bus.aluop          = ALU_ADD;
    bus.reg_we         = 1'b0;
    bus.wreg_dst_sel   = 1'b0;
    bus.wrbck_data_sel = 1'b0;
    bus.instr_done     = 1'b0;
    bus.halted         = 1'b0;
    bus.state_debug    = state;

    case (state)
      IDLE: state_nxt = FETCH;

      FETCH: begin
        // PC+4 is computed every cycle but only committed with the IR load.
        bus.mem_req      = 1'b1;
        bus.alu_srcb_sel = 2'd1;
        bus.ir_we        = bus.mem_ready;
        bus.pc_we        = bus.mem_ready;
        if (bus.mem_ready) state_nxt = DECODE;
      end

      DECODE: begin
        // Speculative branch target into ALUOut.
        bus.alu_srcb_sel = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPE_EX;
          OP_BEQ:       state_nxt = BEQ_EX;
          OP_ADDI:      state_nxt = ADDI_EX;
          OP_J:         state_nxt = JMP_EX;
          default:      state_nxt = HALT;
        endcase
      end

      MEMADR: begin
        bus.alu_srca_sel = 1'b1;
        bus.alu_srcb_sel = 2'd2;
        state_nxt = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_nxt = MEMWB;
      end

      MEMWB: begin
        bus.reg_we         = 1'b1;
        bus.wrbck_data_sel = 1'b1;
        bus.instr_done     = 1'b1;
        state_nxt          = FETCH;
      end

      MEMWR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_nxt      = FETCH;
        end
      end

      RTYPE_EX: begin
        bus.alu_srca_sel = 1'b1;
        bus.aluop        = ALU_FUNCT;
        state_nxt        = RTYPE_WB;
      end

      RTYPE_WB: begin
        bus.reg_we       = 1'b1;
        bus.wreg_dst_sel = 1'b1;
        bus.instr_done   = 1'b1;
        state_nxt        = FETCH;
      end

      BEQ_EX: begin
        bus.alu_srca_sel = 1'b1;
        bus.aluop        = ALU_SUB;
        bus.branch       = 1'b1;
        bus.pc_src       = 2'd1;
        bus.instr_done   = 1'b1;
        state_nxt        = FETCH;
      end

      ADDI_EX: begin
        bus.alu_srca_sel = 1'b1;
        bus.alu_srcb_sel = 2'd2;
        state_nxt        = ADDI_WB;
      end

      ADDI_WB: begin
        bus.reg_we     = 1'b1;
        bus.instr_done = 1'b1;
        state_nxt      = FETCH;
      end

      JMP_EX: begin
        bus.pc_we      = 1'b1;
        bus.pc_src     = 2'd2;
        bus.instr_done = 1'b1;
        state_nxt      = FETCH;
      end

      HALT: begin
        bus.halted = 1'b1;
        state_nxt  = HALT;
      end

      // Unused encodings behave like IDLE and recover through FETCH.
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_mcu.sv
module tb_multicycle_mcu;

  logic clk = 1'b0;
  logic reset;
  multicycle_mcu_if bus ();

  multicycle_mcu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected vector layout:
  // {state[3:0], mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src[1:0],
  //  srca, srcb[1:0], aluop[3:0], reg_we, dst, wrbck, done, halted}
  typedef logic [23:0] vec_t;

  localparam vec_t E_IDLE    = {4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_FETCH_R = {4'd1,  1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,2'd1,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_FETCH_W = {4'd1,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd1,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_DECODE  = {4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd3,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_MEMADR  = {4'd3,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,2'd2,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_MEMRD   = {4'd4,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_MEMWB   = {4'd5,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b1,1'b1,1'b0};
  localparam vec_t E_MEMWR_W = {4'd6,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_MEMWR_R = {4'd6,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam vec_t E_R_EX    = {4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,2'd0,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_R_WB    = {4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b1,1'b1,1'b0,1'b1,1'b0};
  localparam vec_t E_BEQ     = {4'd9,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1, 1'b1,2'd0,4'd1, 1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam vec_t E_ADDI_EX = {4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,2'd2,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t E_ADDI_WB = {4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam vec_t E_JMP     = {4'd12, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam vec_t E_HALT    = {4'd15, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b1};

  typedef struct {
    string name;
    vec_t  exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic vec_t sample_dut();
    return {bus.state_debug, bus.mem_req, bus.mem_we, bus.iord, bus.ir_we,
            bus.pc_we, bus.branch, bus.pc_src, bus.alu_srca_sel,
            bus.alu_srcb_sel, bus.aluop, bus.reg_we, bus.wreg_dst_sel,
            bus.wrbck_data_sel, bus.instr_done, bus.halted};
  endfunction

  // Monitor: outputs are presented every cycle; check mid-cycle on the
  // falling edge against whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_item_t it;
      vec_t act;
      it  = sb_q.pop_front();
      act = sample_dut();
      tests_run++;
      if (act !== it.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                 it.name, act, it.exp, act[23:20], it.exp[23:20]);
      end
    end
  end

  // Drive inputs for one cycle, queue the expected outputs, advance.
  task automatic step(input string name, input logic mr, input logic [5:0] opc, input vec_t e);
    sb_item_t it;
    bus.mem_ready = mr;
    bus.opcode    = opc;
    it.name = name;
    it.exp  = e;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000000;
    @(posedge clk);
    #1;

    // Reset held low: IDLE, everything zero.
    step("rst_idle0", 1'b1, 6'b000000, E_IDLE);
    step("rst_idle1", 1'b1, 6'b000000, E_IDLE);
    step("rst_idle2", 1'b1, 6'b000000, E_IDLE);
    reset = 1'b1;
    step("rel_idle",  1'b1, 6'b000000, E_IDLE);

    // R-type
    step("r_fetch",  1'b1, 6'b000000, E_FETCH_R);
    step("r_decode", 1'b1, 6'b000000, E_DECODE);
    step("r_ex",     1'b1, 6'b000000, E_R_EX);
    step("r_wb",     1'b1, 6'b000000, E_R_WB);

    // lw with a one-cycle fetch stall and two-cycle read stall
    step("lw_fetch_wait", 1'b0, 6'b100011, E_FETCH_W);
    step("lw_fetch",      1'b1, 6'b100011, E_FETCH_R);
    step("lw_decode",     1'b1, 6'b100011, E_DECODE);
    step("lw_memadr",     1'b1, 6'b100011, E_MEMADR);
    step("lw_memrd_w0",   1'b0, 6'b100011, E_MEMRD);
    step("lw_memrd_w1",   1'b0, 6'b100011, E_MEMRD);
    step("lw_memrd",      1'b1, 6'b100011, E_MEMRD);
    step("lw_memwb",      1'b1, 6'b100011, E_MEMWB);

    // sw with one write stall
    step("sw_fetch",    1'b1, 6'b101011, E_FETCH_R);
    step("sw_decode",   1'b1, 6'b101011, E_DECODE);
    step("sw_memadr",   1'b0, 6'b101011, E_MEMADR);
    step("sw_memwr_w",  1'b0, 6'b101011, E_MEMWR_W);
    step("sw_memwr",    1'b1, 6'b101011, E_MEMWR_R);

    // beq
    step("beq_fetch",  1'b1, 6'b000100, E_FETCH_R);
    step("beq_decode", 1'b1, 6'b000100, E_DECODE);
    step("beq_ex",     1'b1, 6'b000100, E_BEQ);

    // j
    step("j_fetch",  1'b1, 6'b000010, E_FETCH_R);
    step("j_decode", 1'b1, 6'b000010, E_DECODE);
    step("j_ex",     1'b1, 6'b000010, E_JMP);

    // addi
    step("addi_fetch",  1'b1, 6'b001000, E_FETCH_R);
    step("addi_decode", 1'b1, 6'b001000, E_DECODE);
    step("addi_ex",     1'b1, 6'b001000, E_ADDI_EX);
    step("addi_wb",     1'b1, 6'b001000, E_ADDI_WB);

    // lw aborted by reset while waiting in MEMRD
    step("abort_fetch",  1'b1, 6'b100011, E_FETCH_R);
    step("abort_decode", 1'b1, 6'b100011, E_DECODE);
    step("abort_memadr", 1'b1, 6'b100011, E_MEMADR);
    step("abort_memrd",  1'b0, 6'b100011, E_MEMRD);
    reset = 1'b0;
    step("abort_idle",   1'b1, 6'b100011, E_IDLE);
    reset = 1'b1;
    step("abort_rel",    1'b1, 6'b100011, E_IDLE);

    // Unknown opcode halts permanently
    step("halt_fetch",  1'b1, 6'b111111, E_FETCH_R);
    step("halt_decode", 1'b1, 6'b111111, E_DECODE);
    for (int i = 0; i < 20; i++)
      step("halt_hold", logic'(i[0]), 6'b111111, E_HALT);

    @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
